// File: rtl/fwd_pkg.sv
// Shared types for the write-back tracking / forwarding unit: result-source
// encoding (matches MemtoReg) and the per-slot control record.
package fwd_pkg;

  typedef enum logic [1:0] {
    SEL_ALU  = 2'b00,
    SEL_MEM  = 2'b01,
    SEL_PC4  = 2'b10,
    SEL_NONE = 2'b11
  } sel_e;

  // a3 and data are width-parametrised, so they live beside this record in the top.
  typedef struct packed {
    logic valid;
    logic ready;
    sel_e sel;
  } slot_ctl_t;

  localparam int unsigned DEPTH_MIN = 3;
  localparam int unsigned DEPTH_MAX = 8;

  function automatic logic ready_at_issue(input sel_e sel);
    return (sel == SEL_PC4) || (sel == SEL_NONE);
  endfunction

endpackage

// File: rtl/fwd_match.sv
// Newest-match priority search for one register-read port over all in-flight slots.
module fwd_match #(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3
) (
  input  logic [DEPTH-1:0]       slot_valid,
  input  logic [DEPTH-1:0]       slot_ready,
  input  logic [DEPTH*AW-1:0]    slot_a3,
  input  logic [DEPTH*WIDTH-1:0] slot_data,
  input  logic [AW-1:0]          rd_a,
  input  logic [WIDTH-1:0]       rd_grf,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   rd_stall
);

  // Walk oldest to newest so the lowest slot index overrides and wins.
  always_comb begin
    rd_data  = rd_grf;
    rd_stall = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (slot_valid[k] && (rd_a != '0) && (slot_a3[k*AW +: AW] == rd_a)) begin
        rd_data  = slot_data[k*WIDTH +: WIDTH];
        rd_stall = ~slot_ready[k];
      end
    end
  end

endmodule

// File: rtl/fwd_bypass.sv
// In-flight result pipeline: tracks destination/source/data per instruction,
// forwards the newest match to NREAD read ports, and writes back from the last slot.
module fwd_bypass
  import fwd_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 3,
  parameter int NREAD = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   stall,
  input  logic                   iss_valid,
  input  logic [AW-1:0]          iss_a3,
  input  logic [1:0]             iss_sel,
  input  logic [WIDTH-1:0]       iss_pc4,
  input  logic [WIDTH-1:0]       alu_c,
  input  logic [WIDTH-1:0]       mem_rd,
  input  logic [NREAD*AW-1:0]    rd_a,
  input  logic [NREAD*WIDTH-1:0] rd_grf,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic                   rd_stall,
  output logic                   wb_we,
  output logic [AW-1:0]          wb_a3,
  output logic [WIDTH-1:0]       wb_wd
);

  if (DEPTH < DEPTH_MIN || DEPTH > DEPTH_MAX) begin : g_depth_check
    $error("fwd_bypass: DEPTH out of range 3..8");
  end

  slot_ctl_t        ctl_q  [DEPTH];
  logic [AW-1:0]    a3_q   [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];

  sel_e iss_sel_e;
  assign iss_sel_e = sel_e'(iss_sel);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        ctl_q[k]  <= '0;
        a3_q[k]   <= '0;
        data_q[k] <= '0;
      end
    end else if (!stall) begin
      if (iss_valid) begin
        ctl_q[0].valid <= 1'b1;
        ctl_q[0].ready <= ready_at_issue(iss_sel_e);
        ctl_q[0].sel   <= iss_sel_e;
        a3_q[0]        <= iss_a3;
        data_q[0]      <= (iss_sel_e == SEL_PC4) ? iss_pc4 : '0;
      end else begin
        ctl_q[0]  <= '0;
        a3_q[0]   <= '0;
        data_q[0] <= '0;
      end

      for (int k = 1; k < DEPTH; k++) begin
        ctl_q[k]  <= ctl_q[k-1];
        a3_q[k]   <= a3_q[k-1];
        data_q[k] <= data_q[k-1];
      end

      // E-stage result lands on the move into slot 1, memory data on the move into slot 2.
      if (ctl_q[0].sel == SEL_ALU) begin
        ctl_q[1].ready <= 1'b1;
        data_q[1]      <= alu_c;
      end
      if (ctl_q[1].sel == SEL_MEM) begin
        ctl_q[2].ready <= 1'b1;
        data_q[2]      <= mem_rd;
      end
    end
  end

  logic [DEPTH-1:0]       slot_valid;
  logic [DEPTH-1:0]       slot_ready;
  logic [DEPTH*AW-1:0]    slot_a3;
  logic [DEPTH*WIDTH-1:0] slot_data;

  always_comb begin
    slot_valid = '0;
    slot_ready = '0;
    slot_a3    = '0;
    slot_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot_valid[k]              = ctl_q[k].valid;
      slot_ready[k]              = ctl_q[k].ready;
      slot_a3[k*AW +: AW]        = a3_q[k];
      slot_data[k*WIDTH +: WIDTH] = data_q[k];
    end
  end

  logic [NREAD-1:0] port_stall;

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    fwd_match #(
      .WIDTH (WIDTH),
      .AW    (AW),
      .DEPTH (DEPTH)
    ) u_match (
      .slot_valid (slot_valid),
      .slot_ready (slot_ready),
      .slot_a3    (slot_a3),
      .slot_data  (slot_data),
      .rd_a       (rd_a[p*AW +: AW]),
      .rd_grf     (rd_grf[p*WIDTH +: WIDTH]),
      .rd_data    (rd_data[p*WIDTH +: WIDTH]),
      .rd_stall   (port_stall[p])
    );
  end

  assign rd_stall = |port_stall;

  assign wb_we = ctl_q[DEPTH-1].valid && (a3_q[DEPTH-1] != '0);
  assign wb_a3 = wb_we ? a3_q[DEPTH-1]   : '0;
  assign wb_wd = wb_we ? data_q[DEPTH-1] : '0;

endmodule

// File: tb/tb_fwd_bypass.sv
// Directed bench for fwd_bypass: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fwd_bypass;
  import fwd_pkg::*;

  localparam int WIDTH = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 3;
  localparam int NREAD = 2;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   stall;
  logic                   iss_valid;
  logic [AW-1:0]          iss_a3;
  logic [1:0]             iss_sel;
  logic [WIDTH-1:0]       iss_pc4;
  logic [WIDTH-1:0]       alu_c;
  logic [WIDTH-1:0]       mem_rd;
  logic [NREAD*AW-1:0]    rd_a;
  logic [NREAD*WIDTH-1:0] rd_grf;
  logic [NREAD*WIDTH-1:0] rd_data;
  logic                   rd_stall;
  logic                   wb_we;
  logic [AW-1:0]          wb_a3;
  logic [WIDTH-1:0]       wb_wd;

  fwd_bypass #(.WIDTH(WIDTH), .AW(AW), .DEPTH(DEPTH), .NREAD(NREAD)) dut (
    .clk(clk), .reset(reset), .stall(stall), .iss_valid(iss_valid),
    .iss_a3(iss_a3), .iss_sel(iss_sel), .iss_pc4(iss_pc4), .alu_c(alu_c),
    .mem_rd(mem_rd), .rd_a(rd_a), .rd_grf(rd_grf), .rd_data(rd_data),
    .rd_stall(rd_stall), .wb_we(wb_we), .wb_a3(wb_a3), .wb_wd(wb_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    string                  name;
    logic [NREAD*WIDTH-1:0] rdd;
    logic                   st;
    logic                   we;
    logic [AW-1:0]          a3;
    logic [WIDTH-1:0]       wd;
  } exp_t;

  exp_t q[$];
  logic smp = 1'b0;
  int   nvec = 0;
  int   nfail = 0;

  // Monitor: one expectation per sampled negedge.
  always @(negedge clk) begin
    if (smp) begin
      exp_t e;
      logic bad;
      nvec++;
      if (q.size() == 0) begin
        nfail++;
        $display("FAIL scoreboard_empty: sample with no expectation queued");
      end else begin
        e = q.pop_front();
        bad = (rd_stall !== e.st) || (wb_we !== e.we) || (wb_a3 !== e.a3) ||
              (wb_wd !== e.wd) || (!e.st && (rd_data !== e.rdd));
        if (bad) begin
          nfail++;
          $display("FAIL %s: got rd_data=%h rd_stall=%b wb=%b/%0d/%h, want rd_data=%h rd_stall=%b wb=%b/%0d/%h",
                   e.name, rd_data, rd_stall, wb_we, wb_a3, wb_wd,
                   e.rdd, e.st, e.we, e.a3, e.wd);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d0,
                     input logic st, input logic we, input logic [AW-1:0] a3,
                     input logic [WIDTH-1:0] wd);
    exp_t e;
    e.name = name;
    e.rdd  = {d1, d0};
    e.st   = st;
    e.we   = we;
    e.a3   = a3;
    e.wd   = wd;
    q.push_back(e);
    smp = 1'b1;
    @(negedge clk);
    #1;
    smp = 1'b0;
  endtask

  task automatic issue(input logic [AW-1:0] a3, input logic [1:0] sel, input logic [WIDTH-1:0] pc4);
    iss_valid = 1'b1;
    iss_a3    = a3;
    iss_sel   = sel;
    iss_pc4   = pc4;
  endtask

  task automatic set_rd(input logic [AW-1:0] a1, input logic [AW-1:0] a0);
    rd_a = {a1, a0};
  endtask

  localparam logic [WIDTH-1:0] G0 = 32'h0000_1234;
  localparam logic [WIDTH-1:0] G1 = 32'h0000_BEEF;

  initial begin
    reset = 1'b0; stall = 1'b0; iss_valid = 1'b0; iss_a3 = '0; iss_sel = SEL_NONE;
    iss_pc4 = '0; alu_c = '0; mem_rd = '0;
    rd_grf = {G1, G0};
    set_rd(5'd1, 5'd5);
    #2;
    chk("reset_idle", G1, G0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick(); tick();
    chk("idle_grf", G1, G0, 1'b0, 1'b0, '0, '0);

    // ALU result forwarded from slot 1 and written back from slot 2
    issue(5'd8, SEL_ALU, 32'h8888);
    tick();
    iss_valid = 1'b0; alu_c = 32'hAA; set_rd(5'd1, 5'd8);
    chk("alu_slot0_stall", G1, 32'h0, 1'b1, 1'b0, '0, '0);
    tick();
    alu_c = 32'h0;
    chk("alu_fwd_slot1", G1, 32'hAA, 1'b0, 1'b0, '0, '0);
    tick();
    chk("alu_wb", G1, 32'hAA, 1'b0, 1'b1, 5'd8, 32'hAA);
    tick();
    chk("alu_retired", G1, G0, 1'b0, 1'b0, '0, '0);

    // MEM load: not ready until captured into slot 2
    issue(5'd9, SEL_MEM, 32'h9999);
    alu_c = 32'h99;
    tick();
    iss_valid = 1'b0; set_rd(5'd1, 5'd9);
    chk("mem_slot0_stall", G1, 32'h0, 1'b1, 1'b0, '0, '0);
    tick();
    mem_rd = 32'h55;
    chk("mem_slot1_stall", G1, 32'h0, 1'b1, 1'b0, '0, '0);
    tick();
    mem_rd = 32'h0;
    chk("mem_captured", G1, 32'h55, 1'b0, 1'b1, 5'd9, 32'h55);
    tick();

    // Two writers of r3: newest wins on both ports, older writes back first
    issue(5'd3, SEL_PC4, 32'h3004);
    tick();
    issue(5'd3, SEL_ALU, 32'h3008);
    tick();
    iss_valid = 1'b0; alu_c = 32'h77; set_rd(5'd3, 5'd3);
    chk("newest_not_ready", 32'h0, 32'h0, 1'b1, 1'b0, '0, '0);
    tick();
    alu_c = 32'h0;
    chk("newest_wins_old_wb", 32'h77, 32'h77, 1'b0, 1'b1, 5'd3, 32'h3004);
    tick();
    chk("newest_wb", 32'h77, 32'h77, 1'b0, 1'b1, 5'd3, 32'h77);
    tick();
    chk("r3_retired", G1, G0, 1'b0, 1'b0, '0, '0);

    // Writes to r0 are never forwarded nor written back
    issue(5'd0, SEL_PC4, 32'h5004);
    tick();
    iss_valid = 1'b0; set_rd(5'd1, 5'd0);
    chk("r0_slot0_nofwd", G1, G0, 1'b0, 1'b0, '0, '0);
    tick(); tick();
    chk("r0_no_wb", G1, G0, 1'b0, 1'b0, '0, '0);
    tick();

    // Stall freezes a MEM entry in slot 1; capture on first unstalled edge
    issue(5'd12, SEL_MEM, 32'hC0C0);
    tick();
    iss_valid = 1'b0; set_rd(5'd1, 5'd12);
    tick();
    stall = 1'b1; mem_rd = 32'hDEAD;
    tick();
    chk("stall_hold_1", G1, 32'h0, 1'b1, 1'b0, '0, '0);
    tick();
    chk("stall_hold_2", G1, 32'h0, 1'b1, 1'b0, '0, '0);
    stall = 1'b0; mem_rd = 32'h66;
    issue(5'd7, SEL_PC4, 32'h7004);
    set_rd(5'd7, 5'd12);
    tick();
    iss_valid = 1'b0; mem_rd = 32'h0;
    chk("unstall_capture", 32'h7004, 32'h66, 1'b0, 1'b1, 5'd12, 32'h66);

    // Asynchronous reset mid-stream drops everything
    reset = 1'b0;
    chk("async_reset", G1, G0, 1'b0, 1'b0, '0, '0);
    reset = 1'b1;
    tick(); tick();
    chk("dropped_after_reset", G1, G0, 1'b0, 1'b0, '0, '0);

    tick();
    if (q.size() != 0) begin
      nfail++;
      $display("FAIL scoreboard_leftover: %0d expectations never checked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
